// File: rtl/vrased_rst_pkg.sv
// Shared types and constants for the VRASED reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vrased_rst_pkg;

  // Default number of monitor violation sources.
  localparam int N_SRC_DEF = 6;

  // Bit positions of each monitor inside the viol vector.
  localparam int SRC_XSTACK     = 0;
  localparam int SRC_AC         = 1;
  localparam int SRC_ATOMICITY  = 2;
  localparam int SRC_DMA_AC     = 3;
  localparam int SRC_DMA_DETECT = 4;
  localparam int SRC_DMA_XSTACK = 5;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    GUARD = 2'd2
  } rst_state_t;

  // Counter width able to hold max_val-1 (at least one bit).
  function automatic int timer_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/vrased_hold_timer.sv
// Loadable down-counter that stops at zero and flags it.
// Latency: load/decrement visible one cycle after the sampling edge.
// Backpressure: none; load has priority over decrement.
module vrased_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Count register: load wins, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vrased_reset_ctrl.sv
// Stretches VRASED violations into a registered CPU reset and guards re-entry via the reset handler.
// Latency: sys_rst/busy/records update one cycle after the sampling edge.
// Backpressure: none; viol is a level sampled every cycle and cannot be stalled.
module vrased_reset_ctrl
  import vrased_rst_pkg::*;
#(
  parameter int          N_SRC         = N_SRC_DEF,
  parameter int          RST_HOLD      = 16,
  parameter int          GUARD_MAX     = 64,
  parameter int          CNT_W         = 8,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] viol,
  input  logic [15:0]      pc,
  input  logic             cause_clr,
  output logic             sys_rst,
  output logic             busy,
  output logic [N_SRC-1:0] cause_first,
  output logic [N_SRC-1:0] cause_acc,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             guard_to
);

  localparam int HW = timer_width(RST_HOLD);
  localparam int GW = timer_width(GUARD_MAX);
  localparam logic [HW-1:0]    HOLD_LOAD  = HW'(RST_HOLD - 1);
  localparam logic [GW-1:0]    GUARD_LOAD = GW'(GUARD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  rst_state_t state, state_nxt;
  logic       any_viol;
  logic       pc_hit;
  logic       hold_load, hold_zero;
  logic       guard_load, guard_zero;
  logic       event_hit;
  logic       timeout;

  assign any_viol = |viol;
  assign pc_hit   = (pc == RESET_HANDLER);

  // Reset-hold timer: counts the remaining cycles of sys_rst.
  vrased_hold_timer #(.W(HW)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .dec      (state == HOLD),
    .zero     (hold_zero)
  );

  // Guard timer: bounds how long the CPU may take to reach the handler.
  vrased_hold_timer #(.W(GW)) u_guard_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (guard_load),
    .load_val (GUARD_LOAD),
    .dec      (state == GUARD),
    .zero     (guard_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, timer loads and event/timeout strobes; viol beats a pc match in GUARD.
  always_comb begin
    state_nxt  = state;
    hold_load  = 1'b0;
    guard_load = 1'b0;
    event_hit  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (any_viol) begin
          state_nxt = HOLD;
          hold_load = 1'b1;
          event_hit = 1'b1;
        end
      end
      HOLD: begin
        if (any_viol) begin
          // Extension of the current reset, not a new event.
          hold_load = 1'b1;
        end else if (hold_zero) begin
          state_nxt  = GUARD;
          guard_load = 1'b1;
        end
      end
      GUARD: begin
        if (any_viol) begin
          state_nxt = HOLD;
          hold_load = 1'b1;
          event_hit = 1'b1;
        end else if (pc_hit) begin
          state_nxt = IDLE;
        end else if (guard_zero) begin
          state_nxt = HOLD;
          hold_load = 1'b1;
          timeout   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered reset request and busy, decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sys_rst <= 1'b0;
      busy    <= 1'b0;
    end else begin
      sys_rst <= (state_nxt == HOLD);
      busy    <= (state_nxt != IDLE);
    end
  end

  // Sticky records: a clear is applied first, then the current cycle's event is layered on top.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_first <= '0;
      cause_acc   <= '0;
      viol_cnt    <= '0;
      guard_to    <= 1'b0;
    end else begin
      cause_acc <= (cause_clr ? '0 : cause_acc) | viol;

      if (event_hit && (cause_clr || (cause_first == '0))) begin
        cause_first <= viol;
      end else if (cause_clr) begin
        cause_first <= '0;
      end

      if (event_hit) begin
        if (cause_clr) begin
          viol_cnt <= CNT_W'(1);
        end else if (viol_cnt != CNT_MAX) begin
          viol_cnt <= viol_cnt + CNT_W'(1);
        end
      end else if (cause_clr) begin
        viol_cnt <= '0;
      end

      if (timeout) begin
        guard_to <= 1'b1;
      end else if (cause_clr) begin
        guard_to <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
module tb_vrased_reset_ctrl;

  localparam int RH = 16;
  localparam int GM = 64;
  localparam logic [15:0] PC_IDLE = 16'h1234;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  viol;
  logic [15:0] pc;
  logic        cause_clr;

  logic        sys_rst, busy, guard_to;
  logic [5:0]  cause_first, cause_acc;
  logic [7:0]  viol_cnt;

  logic        sys_rst2, busy2, guard_to2;
  logic [5:0]  cause_first2, cause_acc2;
  logic [1:0]  viol_cnt2;

  int total = 0;
  int bad   = 0;

  // Reference model: phase plus "cycles of reset still owed" and "guard cycles used".
  localparam int P_IDLE = 0, P_RST = 1, P_WAIT = 2;
  int         m_phase, m_rst_left, m_wait_used, m_cnt;
  logic [5:0] m_first, m_acc;
  logic       m_gto;

  always #5 clk = ~clk;

  vrased_reset_ctrl dut (
    .clk(clk), .reset(reset), .viol(viol), .pc(pc), .cause_clr(cause_clr),
    .sys_rst(sys_rst), .busy(busy), .cause_first(cause_first),
    .cause_acc(cause_acc), .viol_cnt(viol_cnt), .guard_to(guard_to)
  );

  vrased_reset_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .viol(viol), .pc(pc), .cause_clr(cause_clr),
    .sys_rst(sys_rst2), .busy(busy2), .cause_first(cause_first2),
    .cause_acc(cause_acc2), .viol_cnt(viol_cnt2), .guard_to(guard_to2)
  );

  task automatic model_step();
    bit ev, to;
    ev = 0;
    to = 0;
    if (reset) begin
      m_phase = P_IDLE; m_rst_left = 0; m_wait_used = 0;
      m_first = '0; m_acc = '0; m_cnt = 0; m_gto = 0;
      return;
    end
    if (m_phase == P_IDLE) begin
      if (viol != 0) begin ev = 1; m_phase = P_RST; m_rst_left = RH; end
    end else if (m_phase == P_RST) begin
      if (viol != 0) m_rst_left = RH;
      else m_rst_left = m_rst_left - 1;
      if (m_rst_left == 0) begin m_phase = P_WAIT; m_wait_used = 0; end
    end else begin
      m_wait_used = m_wait_used + 1;
      if (viol != 0) begin ev = 1; m_phase = P_RST; m_rst_left = RH; end
      else if (pc == 16'h0000) m_phase = P_IDLE;
      else if (m_wait_used == GM) begin to = 1; m_phase = P_RST; m_rst_left = RH; end
    end
    if (cause_clr) begin m_first = '0; m_acc = '0; m_cnt = 0; m_gto = 0; end
    m_acc = m_acc | viol;
    if (ev) begin
      if (m_cnt < 1000) m_cnt = m_cnt + 1;
      if (m_first == 0) m_first = viol;
    end
    if (to) m_gto = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Wait for the reset request to drop (bounded).
  task automatic wait_release();
    int n = 0;
    while (sys_rst && n < 300) begin tick(); n++; end
    total++;
    if (sys_rst) begin bad++; $display("FAIL wait_release: sys_rst=%0b still high, want 0", sys_rst); end
  endtask

  // Let reset drop, then fetch from the handler to return to IDLE.
  task automatic drain();
    wait_release();
    pc = 16'h0000; tick(); pc = PC_IDLE;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL drain_idle: busy=%0b want 0", busy); end
  endtask

  task automatic test_reset();
    reset = 1; viol = '0; pc = PC_IDLE; cause_clr = 0;
    tick(); tick();
    total++;
    if ({sys_rst, busy, guard_to, cause_first, cause_acc, viol_cnt} !== 23'h0) begin
      bad++; $display("FAIL reset_a: got %h want 0", {sys_rst, busy, guard_to, cause_first, cause_acc, viol_cnt});
    end
    total++;
    if ({sys_rst2, busy2, guard_to2, cause_first2, cause_acc2, viol_cnt2} !== 17'h0) begin
      bad++; $display("FAIL reset_b: got %h want 0", {sys_rst2, busy2, guard_to2, cause_first2, cause_acc2, viol_cnt2});
    end
    reset = 0;
  endtask

  task automatic test_single_event();
    int hi = 0;
    viol = 6'h02; tick(); viol = '0;
    for (int k = 0; k < 100 && sys_rst; k++) begin hi++; tick(); end
    total++;
    if (hi != RH) begin bad++; $display("FAIL single_hold_len: got %0d want %0d", hi, RH); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_guard_busy: got %0b want 1", busy); end
    tick(); tick();
    pc = 16'h0000; tick(); pc = PC_IDLE;
    total++;
    if ({busy, sys_rst} !== 2'b00) begin bad++; $display("FAIL single_idle: busy/sys_rst=%b want 00", {busy, sys_rst}); end
    total++;
    if ({cause_first, cause_acc, viol_cnt} !== {6'h02, 6'h02, 8'd1}) begin
      bad++; $display("FAIL single_records: first=%h acc=%h cnt=%0d want 02 02 1", cause_first, cause_acc, viol_cnt);
    end
  endtask

  task automatic test_extend();
    int hi = 0;
    reset = 1; tick(); reset = 0;
    viol = 6'h01; tick(); viol = '0;
    for (int k = 1; k <= 9; k++) begin if (sys_rst) hi++; tick(); end
    viol = 6'h08;
    if (sys_rst) hi++;
    tick(); viol = '0;
    for (int k = 0; k < 100 && sys_rst; k++) begin hi++; tick(); end
    total++;
    if (hi != 10 + RH) begin bad++; $display("FAIL extend_len: got %0d want %0d", hi, 10 + RH); end
    total++;
    if ({cause_first, cause_acc, viol_cnt} !== {6'h01, 6'h09, 8'd1}) begin
      bad++; $display("FAIL extend_records: first=%h acc=%h cnt=%0d want 01 09 1", cause_first, cause_acc, viol_cnt);
    end
  endtask

  task automatic test_guard_timeout();
    int g = 0;
    for (int k = 0; k < 200 && !sys_rst && busy; k++) begin g++; tick(); end
    total++;
    if (g != GM) begin bad++; $display("FAIL guard_len: got %0d want %0d", g, GM); end
    total++;
    if ({sys_rst, guard_to, viol_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      bad++; $display("FAIL guard_timeout: sys_rst=%0b guard_to=%0b cnt=%0d want 1 1 1", sys_rst, guard_to, viol_cnt);
    end
  endtask

  task automatic test_viol_beats_pc();
    wait_release();
    viol = 6'h20; pc = 16'h0000; tick(); viol = '0; pc = PC_IDLE;
    total++;
    if ({sys_rst, busy} !== 2'b11) begin bad++; $display("FAIL beat_state: sys_rst/busy=%b want 11", {sys_rst, busy}); end
    total++;
    if ({viol_cnt, cause_first, cause_acc} !== {8'd2, 6'h01, 6'h29}) begin
      bad++; $display("FAIL beat_records: cnt=%0d first=%h acc=%h want 2 01 29", viol_cnt, cause_first, cause_acc);
    end
    drain();
  endtask

  task automatic test_clr_event();
    viol = 6'h04; cause_clr = 1; tick(); viol = '0; cause_clr = 0;
    total++;
    if ({viol_cnt, cause_first, cause_acc, guard_to} !== {8'd1, 6'h04, 6'h04, 1'b0}) begin
      bad++; $display("FAIL clr_event: cnt=%0d first=%h acc=%h gto=%0b want 1 04 04 0", viol_cnt, cause_first, cause_acc, guard_to);
    end
    drain();
  endtask

  task automatic test_saturation();
    reset = 1; tick(); reset = 0;
    for (int e = 0; e < 5; e++) begin
      viol = 6'($urandom_range(1, 63)); tick(); viol = '0;
      wait_release();
    end
    total++;
    if (viol_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_cnt2: got %0d want 3", viol_cnt2); end
    total++;
    if (viol_cnt !== 8'd5) begin bad++; $display("FAIL sat_cnt8: got %0d want 5", viol_cnt); end
    drain();
  endtask

  task automatic test_reset_mid_hold();
    viol = 6'h10; tick(); viol = '0;
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (sys_rst !== 1'b1) begin bad++; $display("FAIL midhold_pre: sys_rst=%0b want 1", sys_rst); end
    reset = 1; tick();
    total++;
    if ({sys_rst, busy, guard_to, cause_first, cause_acc, viol_cnt} !== 23'h0) begin
      bad++; $display("FAIL midhold_reset: got %h want 0", {sys_rst, busy, guard_to, cause_first, cause_acc, viol_cnt});
    end
    reset = 0; tick(); tick();
    total++;
    if ({sys_rst, busy} !== 2'b00) begin bad++; $display("FAIL midhold_idle: sys_rst/busy=%b want 00", {sys_rst, busy}); end
  endtask

  task automatic test_random();
    logic [22:0] exp_a;
    logic [16:0] exp_b;
    reset = 1; tick(); reset = 0;
    for (int c = 0; c < 4000; c++) begin
      viol      = ($urandom_range(0, 29) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
      if (c < 2000) pc = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
      else          pc = ($urandom_range(0, 199) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
      cause_clr = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      tick();
      exp_a = {m_phase == P_RST, m_phase != P_IDLE, m_gto, m_first, m_acc,
               8'((m_cnt > 255) ? 255 : m_cnt)};
      exp_b = {m_phase == P_RST, m_phase != P_IDLE, m_gto, m_first, m_acc,
               2'((m_cnt > 3) ? 3 : m_cnt)};
      total++;
      if ({sys_rst, busy, guard_to, cause_first, cause_acc, viol_cnt} !== exp_a) begin
        bad++; $display("FAIL random_a cyc %0d: got %h want %h", c, {sys_rst, busy, guard_to, cause_first, cause_acc, viol_cnt}, exp_a);
      end
      total++;
      if ({sys_rst2, busy2, guard_to2, cause_first2, cause_acc2, viol_cnt2} !== exp_b) begin
        bad++; $display("FAIL random_b cyc %0d: got %h want %h", c, {sys_rst2, busy2, guard_to2, cause_first2, cause_acc2, viol_cnt2}, exp_b);
      end
    end
    viol = '0; cause_clr = 0; reset = 0; pc = PC_IDLE;
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_extend();
    test_guard_timeout();
    test_viol_beats_pc();
    test_clr_event();
    test_saturation();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule
